// File: rtl/rf_wb_ctrl.sv
// Register-file write-back arbiter: single-cycle A writes win, long-latency B writes queue in a FIFO.
// Optional pending-write scoreboard (busy_mask) is built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        RF_clk,
    input  logic        RF_rst,
    input  logic        ena,
    input  logic        a_valid,
    input  logic [4:0]  a_rdc,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_rdc,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rdc,
    output logic        RF_W,
    output logic [4:0]  Rdc,
    output logic [31:0] Rd,
    output logic [31:0] busy_mask,
    output logic [3:0]  q_count
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [4:0]       q_rdc  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic        a_take;
    logic        b_live;
    logic        q_empty;
    logic        drain;
    logic        bypass;
    logic        enq;
    logic [4:0]  head_rdc;
    logic [31:0] head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // b_ready looks only at the registered count, so a full queue refuses even while draining
    assign b_ready   = ena && !RF_rst && (q_count < DEPTH_C);
    assign a_take    = ena && a_valid && (a_rdc != 5'd0);
    assign b_live    = b_valid && b_ready && (b_rdc != 5'd0);
    assign q_empty   = (q_count == 4'd0);
    assign drain     = ena && !a_take && !q_empty;
    assign bypass    = ena && !a_take && q_empty && b_live;
    assign enq       = b_live && !bypass;
    assign head_rdc  = q_rdc[rd_ptr];
    assign head_data = q_data[rd_ptr];

    always_ff @(posedge RF_clk or posedge RF_rst) begin
        if (RF_rst) begin
            RF_W <= 1'b0;
            Rdc  <= 5'd0;
            Rd   <= 32'd0;
        end else if (!ena) begin
            RF_W <= 1'b0;
        end else if (a_take) begin
            RF_W <= 1'b1;
            Rdc  <= a_rdc;
            Rd   <= a_data;
        end else if (drain) begin
            RF_W <= 1'b1;
            Rdc  <= head_rdc;
            Rd   <= head_data;
        end else if (bypass) begin
            RF_W <= 1'b1;
            Rdc  <= b_rdc;
            Rd   <= b_data;
        end else begin
            RF_W <= 1'b0;
        end
    end

    // Entries are discarded on reset by clearing the pointers; storage itself needs no reset
    always_ff @(posedge RF_clk) begin
        if (enq) begin
            q_rdc[wr_ptr]  <= b_rdc;
            q_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge RF_clk or posedge RF_rst) begin
        if (RF_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= 4'd0;
        end else begin
            if (enq) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (drain) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({enq, drain})
                2'b10:   q_count <= q_count + 4'd1;
                2'b01:   q_count <= q_count - 4'd1;
                default: q_count <= q_count;
            endcase
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (ena && iss_valid && (iss_rdc != 5'd0)) begin
            busy_set[iss_rdc] = 1'b1;
        end
        if (drain) begin
            busy_clr[head_rdc] = 1'b1;
        end else if (bypass) begin
            busy_clr[b_rdc] = 1'b1;
        end
    end

    // A new issue to the same register outranks the write that retires it
    always_ff @(posedge RF_clk or posedge RF_rst) begin
        if (RF_rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= (busy_mask & ~busy_clr) | busy_set;
        end
    end
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_rdc};
    assign busy_mask  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: a queue-based reference model predicts every write and state value.
module tb_rf_wb_ctrl;

    localparam int DEPTH = 4;

    logic        RF_clk;
    logic        RF_rst;
    logic        ena;
    logic        a_valid;
    logic [4:0]  a_rdc;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rdc;
    logic [31:0] b_data;
    logic        b_ready;
    logic        iss_valid;
    logic [4:0]  iss_rdc;
    logic        RF_W;
    logic [4:0]  Rdc;
    logic [31:0] Rd;
    logic [31:0] busy_mask;
    logic [3:0]  q_count;

    rf_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .RF_clk(RF_clk), .RF_rst(RF_rst), .ena(ena),
        .a_valid(a_valid), .a_rdc(a_rdc), .a_data(a_data),
        .b_valid(b_valid), .b_rdc(b_rdc), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rdc(iss_rdc),
        .RF_W(RF_W), .Rdc(Rdc), .Rd(Rd),
        .busy_mask(busy_mask), .q_count(q_count)
    );

    typedef struct {
        logic [4:0]  rdc;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        w;
        logic [4:0]  rdc;
        logic [31:0] rd;
        logic [3:0]  qc;
        logic [31:0] busy;
    } st_t;

    wr_t         pend[$];
    wr_t         wq[$];
    st_t         sq[$];
    logic [31:0] mbusy;
    logic [4:0]  last_rdc;
    logic [31:0] last_rd;
    logic        mon_en;
    int          checks;
    int          passes;

    initial begin
        RF_clk = 1'b0;
        forever #5 RF_clk = ~RF_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one state record per cycle, plus a write record popped whenever RF_W is seen
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(posedge RF_clk);
            #1;
            if (mon_en && sq.size() > 0) begin
                s = sq.pop_front();
                chk("rf_w", RF_W, s.w);
                chk("rdc", Rdc, s.rdc);
                chk("rd", Rd, s.rd);
                chk("q_count", q_count, s.qc);
                chk("busy_mask", busy_mask, s.busy);
                if (RF_W === 1'b1) begin
                    if (wq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: got rdc=%0d data=0x%0h expected no write", Rdc, Rd);
                    end else begin
                        w = wq.pop_front();
                        chk("write_rdc", Rdc, w.rdc);
                        chk("write_data", Rd, w.d);
                    end
                end
            end
        end
    end

    task automatic step(input logic e, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ir);
        st_t  s;
        wr_t  w;
        wr_t  nb;
        logic acc;
        logic wrote;
        logic exp_br;
        @(posedge RF_clk);
        #2;
        ena = e; a_valid = av; a_rdc = ar; a_data = ad;
        b_valid = bv; b_rdc = br; b_data = bd; iss_valid = iv; iss_rdc = ir;
        exp_br = e && (pend.size() < DEPTH);
        acc    = bv && exp_br;
        wrote  = 1'b0;
        w      = '{5'd0, 32'd0};
        if (e) begin
            if (av && ar != 5'd0) begin
                w = '{ar, ad};
                wrote = 1'b1;
            end else if (pend.size() > 0) begin
                w = pend.pop_front();
                wrote = 1'b1;
                mbusy[w.rdc] = 1'b0;
            end else if (acc && br != 5'd0) begin
                w = '{br, bd};
                wrote = 1'b1;
                acc = 1'b0;
                mbusy[br] = 1'b0;
            end
            if (acc && br != 5'd0) begin
                nb = '{br, bd};
                pend.push_back(nb);
            end
            if (iv && ir != 5'd0) mbusy[ir] = 1'b1;
        end
        if (wrote) begin
            wq.push_back(w);
            last_rdc = w.rdc;
            last_rd  = w.d;
        end
        s.w = wrote;
        s.rdc = last_rdc;
        s.rd = last_rd;
        s.qc = 4'(pend.size());
`ifdef RF_WB_SCOREBOARD_EN
        s.busy = mbusy;
`else
        s.busy = 32'd0;
`endif
        sq.push_back(s);
        mon_en = 1'b1;
        #1;
        chk("b_ready", b_ready, exp_br);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Fill the queue: A occupies the port while B requests stack up behind it
    task automatic fill(input int n, input logic [4:0] base);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 5'd1 + 5'(i), $urandom, 1'b1, base + 5'(i), $urandom, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(posedge RF_clk);
        #2;
        mon_en = 1'b0;
        sq.delete();
        ena = 1'b1; a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        RF_rst = 1'b1;
        #1;
        chk("rst_rf_w", RF_W, 1'b0);
        chk("rst_q_count", q_count, 4'd0);
        chk("rst_busy_mask", busy_mask, 32'd0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_rdc", Rdc, 5'd0);
        chk("rst_rd", Rd, 32'd0);
        pend.delete();
        wq.delete();
        mbusy = 32'd0;
        last_rdc = 5'd0;
        last_rd = 32'd0;
        repeat (2) @(posedge RF_clk);
        #2;
        RF_rst = 1'b0;
    endtask

    initial begin
        checks = 0; passes = 0; mon_en = 1'b0;
        RF_rst = 1'b0; ena = 1'b0;
        a_valid = 1'b0; a_rdc = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_rdc = 5'd0; b_data = 32'd0;
        iss_valid = 1'b0; iss_rdc = 5'd0;
        mbusy = 32'd0; last_rdc = 5'd0; last_rd = 32'd0;

        do_reset();

        // A and B together on an empty queue: A first, B queued one cycle
        step(1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0);
        idle();
        idle();

        // Register 0 requests vanish
        step(1'b1, 1'b1, 5'd0, 32'hdead, 1'b1, 5'd0, 32'hbeef, 1'b0, 5'd0);
        idle();

        // Full queue and pointer wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            fill(DEPTH, 5'd10 + 5'(r));
            step(1'b1, 1'b1, 5'd7, $urandom, 1'b1, 5'd20, $urandom, 1'b0, 5'd0);
            repeat (DEPTH + 1) idle();
        end

        // Scoreboard set, clear on bypass write, set-over-clear on a drained write
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        idle();

        // Enable low freezes a loaded queue, then draining resumes in order
        fill(3, 5'd24);
        repeat (3) step(1'b0, 1'b1, 5'd4, $urandom, 1'b1, 5'd12, $urandom, 1'b1, 5'd13);
        repeat (4) idle();

        // Reset in the middle of draining three queued entries
        fill(3, 5'd16);
        idle();
        do_reset();
        repeat (4) idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)));
        end
        repeat (DEPTH + 2) idle();

        @(posedge RF_clk);
        #2;
        chk("leftover_writes", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning long-latency write queue entries; legal values 2, 4 or 8.
REQ-002 SHALL have port RF_clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port RF_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have ports a_valid/a_rdc/a_data  input  1/5/32  single-cycle (ALU) write request; no backpressure.
REQ-006 SHALL have ports b_valid/b_rdc/b_data  input  1/5/32  long-latency (load/MDU) write request.
REQ-007 SHALL have port b_ready  output  1  queue can accept a B request this cycle.
REQ-008 SHALL have ports iss_valid/iss_rdc  input  1/5  long-latency instruction issued; destination becomes pending.
REQ-009 SHALL have ports RF_W/Rdc/Rd  output  1/5/32  register file write strobe, address, data; all registered.
REQ-010 SHALL have port busy_mask  output  32  bit n set = register n has a pending long-latency write.
REQ-011 SHALL have port q_count  output  4  current queue occupancy.

Function
REQ-012 SHALL accept a B request when b_valid && b_ready && ena; b_ready = ena && (q_count < DEPTH).
REQ-013 SHALL drop any request (A or B) whose rdc is 0: no write-port output, no queue entry; a dropped B still counts as accepted.
REQ-014 SHALL give A absolute priority: a valid nonzero A request drives RF_W=1, Rdc=a_rdc, Rd=a_data on the next rising edge (latency 1).
REQ-015 SHALL drain the queue head in FIFO order in any enabled cycle with no valid nonzero A request, producing RF_W=1 with head rdc/data one cycle later.
REQ-016 SHALL drive RF_W=0 in a cycle following no write; Rdc/Rd hold their last values.
REQ-017 SHALL support simultaneous enqueue and dequeue when full: b_ready is based on registered q_count, so a full queue deasserts b_ready even if draining this cycle.
REQ-018 SHALL bypass an empty queue: when the queue is empty and no A request is present, an accepted B request writes directly (latency 1) without occupying an entry.
REQ-019 SHALL implement the queue as a circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-020 SHALL set busy_mask[iss_rdc] on an enabled iss_valid with nonzero iss_rdc; bit 0 never sets.
REQ-021 SHALL clear busy_mask[n] in the cycle a B-sourced write to n is driven onto the write port (same edge RF_W rises).
REQ-022 SHALL give set precedence over clear when issue and drain target the same register in the same cycle.
REQ-023 SHALL not reorder B writes; WAW avoidance against A writes is the issuer's responsibility via busy_mask.
REQ-024 SHALL, with ena low, hold queue, pointers, busy_mask, and drive RF_W=0 next cycle.

Reset
REQ-025 SHALL, on RF_rst high (any time, mid-operation included), immediately clear RF_W, Rdc, Rd, busy_mask, q_count and both pointers to 0, discarding queued entries.
REQ-026 SHALL hold b_ready low while RF_rst is high.

Configuration
REQ-027 SHALL compile the scoreboard only when macro RF_WB_SCOREBOARD_EN is defined; without it busy_mask is constant 0, iss_valid/iss_rdc are ignored, and all write-port behaviour is unchanged.

Verification
REQ-028 Reset mid-drain: queue holding 3 entries, assert RF_rst -> RF_W=0, q_count=0, busy_mask=0 immediately; next drain cycle shows no stale write.
REQ-029 Priority: A(rdc=5,0x11) and B(rdc=6,0x22) same cycle, queue empty -> edge 1: Rdc=5 Rd=0x11; edge 2: Rdc=6 Rd=0x22; q_count 1 then 0.
REQ-030 Full/wrap: DEPTH=4, A valid every cycle, 4 B requests -> b_ready=0 after 4th; release A -> 4 writes in order; repeat 3 times, order preserved across pointer wrap.
REQ-031 Register 0: A rdc=0 and B rdc=0 -> no RF_W pulse, q_count unchanged, b_ready stays 1.
REQ-032 Scoreboard: iss rdc=9 -> busy_mask=0x200; B write rdc=9 driven -> bit clears same edge; simultaneous new iss rdc=9 -> bit stays set.
REQ-033 Enable: ena low for 3 cycles with queued entries -> RF_W=0, q_count and busy_mask constant; ena high -> draining resumes in order.
